// File: rtl/learn_costs_engine.sv
// learn_costs_engine: neighbour-table search, cost learning and append over RAM.
// Define LEARN_COSTS_BEST_EN to add the best_id/best_cost/best_valid hint.
module learn_costs_engine #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 10,
  parameter int MAX_NEIGHBORS = 8,
  parameter int BASE_ADDR     = 0,
  parameter int ALPHA_SHIFT   = 2
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start_learnCosts,
  input  logic [WORD_WIDTH-1:0] fsourceID,
  input  logic [WORD_WIDTH-1:0] fbatteryStat,
  input  logic [WORD_WIDTH-1:0] fValue,
  input  logic [WORD_WIDTH-1:0] fclusterID,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  mem_wr,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done_learnCosts,
  output logic                  matched,
  output logic                  dropped,
  output logic [7:0]            entry_index
`ifdef LEARN_COSTS_BEST_EN
  ,
  output logic [WORD_WIDTH-1:0] best_id,
  output logic [WORD_WIDTH-1:0] best_cost,
  output logic                  best_valid
`endif
);

  typedef enum logic [3:0] {
    IDLE, RD_CNT, LD_CNT, RD_ID, CMP_ID, RD_VAL, UPD_VAL,
    WR_BAT, WR_VAL, WR_CLU, WR_ID, WR_CNT, DONE
  } state_t;

  localparam logic [7:0] MAXN = 8'(MAX_NEIGHBORS);

  state_t state_q, state_d;
  logic [WORD_WIDTH-1:0] fsrc_q, fsrc_d, fbat_q, fbat_d;
  logic [WORD_WIDTH-1:0] fclu_q, fclu_d, cost_q, cost_d;
  logic [7:0] idx_q, idx_d, cnt_q, cnt_d, entry_q, entry_d;
  logic hit_q, hit_d, done_q, done_d, busy_q, busy_d;
  logic matched_q, matched_d, dropped_q, dropped_d;

  logic [7:0] cnt_ld;
  logic more, id_hit;
  logic [ADDR_WIDTH-1:0] ent_a;
  logic signed [WORD_WIDTH:0] diff;
  logic [WORD_WIDTH-1:0] step;

  assign cnt_ld = (mem_rdata > WORD_WIDTH'(MAX_NEIGHBORS)) ? MAXN
                                                          : mem_rdata[7:0];
  assign more   = ({1'b0, idx_q} + 9'd1) < {1'b0, cnt_q};
  assign id_hit = (mem_rdata == fsrc_q);
  assign ent_a  = ADDR_WIDTH'(BASE_ADDR + 1) + ADDR_WIDTH'({idx_q, 2'b00});
  // cost_q still holds fValue until UPD_VAL replaces it
  assign diff   = $signed({1'b0, cost_q}) - $signed({1'b0, mem_rdata});
  assign step   = WORD_WIDTH'(diff >>> ALPHA_SHIFT);

  always_ff @(posedge clock) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_learnCosts && !busy_q) state_d = RD_CNT;
      RD_CNT:  state_d = LD_CNT;
      LD_CNT:  state_d = (cnt_ld == 8'd0) ? WR_ID : RD_ID;
      RD_ID:   state_d = CMP_ID;
      CMP_ID: begin
        if (id_hit)            state_d = RD_VAL;
        else if (more)         state_d = RD_ID;
        else if (cnt_q < MAXN) state_d = WR_ID;
        else                   state_d = DONE;
      end
      RD_VAL:  state_d = UPD_VAL;
      UPD_VAL: state_d = WR_BAT;
      WR_ID:   state_d = WR_BAT;
      WR_BAT:  state_d = WR_VAL;
      WR_VAL:  state_d = WR_CLU;
      WR_CLU:  state_d = hit_q ? DONE : WR_CNT;
      WR_CNT:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr    = 1'b0;
    unique case (state_q)
      RD_CNT:  mem_addr = ADDR_WIDTH'(BASE_ADDR);
      RD_ID:   mem_addr = ent_a;
      RD_VAL:  mem_addr = ent_a + ADDR_WIDTH'(2);
      WR_ID: begin
        mem_addr = ent_a; mem_wdata = fsrc_q; mem_wr = 1'b1;
      end
      WR_BAT: begin
        mem_addr = ent_a + ADDR_WIDTH'(1); mem_wdata = fbat_q; mem_wr = 1'b1;
      end
      WR_VAL: begin
        mem_addr = ent_a + ADDR_WIDTH'(2); mem_wdata = cost_q; mem_wr = 1'b1;
      end
      WR_CLU: begin
        mem_addr = ent_a + ADDR_WIDTH'(3); mem_wdata = fclu_q; mem_wr = 1'b1;
      end
      WR_CNT: begin
        mem_addr  = ADDR_WIDTH'(BASE_ADDR);
        mem_wdata = WORD_WIDTH'(cnt_q) + WORD_WIDTH'(1);
        mem_wr    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    fsrc_d = fsrc_q; fbat_d = fbat_q; fclu_d = fclu_q; cost_d = cost_q;
    idx_d = idx_q; cnt_d = cnt_q; hit_d = hit_q; entry_d = entry_q;
    matched_d = matched_q; dropped_d = dropped_q;
    if (state_q == IDLE && state_d == RD_CNT) begin
      fsrc_d = fsourceID; fbat_d = fbatteryStat;
      fclu_d = fclusterID; cost_d = fValue; hit_d = 1'b0;
    end
    unique case (state_q)
      LD_CNT: begin cnt_d = cnt_ld; idx_d = 8'd0; end
      CMP_ID: begin
        if (id_hit)    hit_d = 1'b1;
        else if (more) idx_d = idx_q + 8'd1;
        else           idx_d = cnt_q;
      end
      UPD_VAL: cost_d = mem_rdata + step;
      DONE: begin
        matched_d = hit_q;
        dropped_d = !hit_q && (cnt_q == MAXN);
        entry_d   = idx_q;
      end
      default: ;
    endcase
    done_d = (state_q == DONE);
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      fsrc_q <= '0; fbat_q <= '0; fclu_q <= '0; cost_q <= '0;
      idx_q <= '0; cnt_q <= '0; entry_q <= '0; hit_q <= 1'b0;
      done_q <= 1'b0; busy_q <= 1'b0;
      matched_q <= 1'b0; dropped_q <= 1'b0;
    end else begin
      fsrc_q <= fsrc_d; fbat_q <= fbat_d; fclu_q <= fclu_d; cost_q <= cost_d;
      idx_q <= idx_d; cnt_q <= cnt_d; entry_q <= entry_d; hit_q <= hit_d;
      done_q <= done_d; busy_q <= busy_d;
      matched_q <= matched_d; dropped_q <= dropped_d;
    end
  end

  assign busy            = busy_q;
  assign done_learnCosts = done_q;
  assign matched         = matched_q;
  assign dropped         = dropped_q;
  assign entry_index     = entry_q;

`ifdef LEARN_COSTS_BEST_EN
  logic [WORD_WIDTH-1:0] best_id_q, best_id_d, best_cost_q, best_cost_d;
  logic best_valid_q, best_valid_d;

  always_comb begin
    best_id_d = best_id_q; best_cost_d = best_cost_q;
    best_valid_d = best_valid_q;
    if (state_q == WR_VAL &&
        (!best_valid_q || cost_q < best_cost_q || fsrc_q == best_id_q)) begin
      best_id_d = fsrc_q; best_cost_d = cost_q; best_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      best_id_q <= '0; best_cost_q <= '1; best_valid_q <= 1'b0;
    end else begin
      best_id_q <= best_id_d; best_cost_q <= best_cost_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign best_id    = best_id_q;
  assign best_cost  = best_cost_q;
  assign best_valid = best_valid_q;
`endif

endmodule

// File: tb/tb_learn_costs_engine.sv
// tb_learn_costs_engine: directed tests with a behavioural RAM and write log.
// Build with LEARN_COSTS_BEST_EN defined to also exercise the best-cost hint.
module tb_learn_costs_engine;
  logic clock = 1'b0;
  logic nreset, start_learnCosts, mem_wr, busy, done_learnCosts;
  logic matched, dropped;
  logic [15:0] fsourceID, fbatteryStat, fValue, fclusterID;
  logic [15:0] mem_wdata, mem_rdata;
  logic [9:0] mem_addr;
  logic [7:0] entry_index;
`ifdef LEARN_COSTS_BEST_EN
  logic [15:0] best_id, best_cost;
  logic best_valid;
`endif

  logic [15:0] ram [0:1023];
  logic [9:0]  wa [0:31];
  logic [15:0] wd [0:31];
  int nw = 0;
  int ecnt = 0;
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  learn_costs_engine dut (
    .clock(clock), .nreset(nreset), .start_learnCosts(start_learnCosts),
    .fsourceID(fsourceID), .fbatteryStat(fbatteryStat), .fValue(fValue),
    .fclusterID(fclusterID), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata), .busy(busy),
    .done_learnCosts(done_learnCosts), .matched(matched),
    .dropped(dropped), .entry_index(entry_index)
`ifdef LEARN_COSTS_BEST_EN
    , .best_id(best_id), .best_cost(best_cost), .best_valid(best_valid)
`endif
  );

  always @(posedge clock) begin
    ecnt <= ecnt + 1;
    mem_rdata <= ram[mem_addr];
    if (mem_wr) begin
      ram[mem_addr] = mem_wdata;
      if (nw < 32) begin
        wa[nw] = mem_addr; wd[nw] = mem_wdata;
      end
      nw = nw + 1;
    end
  end

  task automatic clear_ram();
    for (int i = 0; i < 1024; i++) ram[i] = 16'h0;
  endtask

  task automatic set_entry(input int i, input logic [15:0] id,
                           input logic [15:0] cost);
    ram[1 + 4*i]     = id;
    ram[1 + 4*i + 1] = 16'h00aa;
    ram[1 + 4*i + 2] = cost;
    ram[1 + 4*i + 3] = 16'h00bb;
  endtask

  task automatic run_op(input logic [15:0] id, input logic [15:0] bat,
                        input logic [15:0] val, input logic [15:0] clu,
                        output int lat);
    int s;
    @(negedge clock);
    fsourceID = id; fbatteryStat = bat; fValue = val; fclusterID = clu;
    start_learnCosts = 1'b1; nw = 0;
    @(posedge clock);
    #1 start_learnCosts = 1'b0;
    s = ecnt;
    lat = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (done_learnCosts) begin lat = ecnt - s; break; end
    end
    checks++;
    if (lat < 0) begin errors++; $display("FAIL timeout: no done within 100 cycles"); end
  endtask

  task automatic test_reset();
    nreset = 1'b0; start_learnCosts = 1'b0;
    fsourceID = 0; fbatteryStat = 0; fValue = 0; fclusterID = 0;
    clear_ram();
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done_learnCosts !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done_learnCosts); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b want 0", mem_wr); end
    checks++; if (mem_addr !== 10'd0) begin errors++; $display("FAIL rst_addr: got %0h want 0", mem_addr); end
    checks++; if (mem_wdata !== 16'd0) begin errors++; $display("FAIL rst_wdata: got %0h want 0", mem_wdata); end
    checks++; if ({matched, dropped} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b want 00", {matched, dropped}); end
    checks++; if (entry_index !== 8'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", entry_index); end
`ifdef LEARN_COSTS_BEST_EN
    checks++; if ({best_valid, best_id, best_cost} !== {1'b0, 16'h0, 16'hffff}) begin errors++; $display("FAIL rst_best: got %b %0h %0h want 0 0 ffff", best_valid, best_id, best_cost); end
`endif
    nreset = 1'b1;
  endtask

  task automatic test_append_empty();
    int lat;
    logic [9:0]  ea [0:4];
    logic [15:0] ed [0:4];
    ea = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd0};
    ed = '{16'h5, 16'h50, 16'h64, 16'h2, 16'h1};
    clear_ram();
    run_op(16'h5, 16'h50, 16'h64, 16'h2, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL app0_lat: got %0d want 8", lat); end
    checks++; if (nw !== 5) begin errors++; $display("FAIL app0_nw: got %0d want 5", nw); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        errors++; $display("FAIL app0_wr%0d: got %0d=%0h want %0d=%0h", i, wa[i], wd[i], ea[i], ed[i]);
      end
    end
    checks++; if ({matched, dropped, entry_index} !== {2'b00, 8'd0}) begin errors++; $display("FAIL app0_flags: got %b%b %0d want 00 0", matched, dropped, entry_index); end
  endtask

  task automatic test_hit(input logic [15:0] old, input logic [15:0] val,
                          input logic [15:0] exp);
    int lat;
    clear_ram();
    ram[0] = 16'd3;
    set_entry(0, 16'd1, 16'd9);
    set_entry(1, 16'd3, 16'd9);
    set_entry(2, 16'd7, old);
    run_op(16'd7, 16'h22, val, 16'h4, lat);
    checks++; if (lat !== 14) begin errors++; $display("FAIL hit_lat: got %0d want 14", lat); end
    checks++; if (ram[11] !== exp) begin errors++; $display("FAIL hit_cost %0d->%0d: got %0d want %0d", old, val, ram[11], exp); end
    checks++; if (ram[10] !== 16'h22 || ram[12] !== 16'h4 || ram[9] !== 16'd7) begin errors++; $display("FAIL hit_fields: got %0h %0h %0h want 7 22 4", ram[9], ram[10], ram[12]); end
    checks++; if (nw !== 3 || ram[0] !== 16'd3) begin errors++; $display("FAIL hit_writes: got nw=%0d cnt=%0d want 3 3", nw, ram[0]); end
    checks++; if ({matched, dropped, entry_index} !== {2'b10, 8'd2}) begin errors++; $display("FAIL hit_flags: got %b%b %0d want 10 2", matched, dropped, entry_index); end
  endtask

  task automatic test_rounding(input logic [15:0] old, input logic [15:0] val,
                               input logic [15:0] exp);
    int lat;
    clear_ram();
    ram[0] = 16'd1;
    set_entry(0, 16'd9, old);
    run_op(16'd9, 16'h1, val, 16'h1, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL rnd_lat: got %0d want 10", lat); end
    checks++; if (ram[3] !== exp) begin errors++; $display("FAIL rnd_cost %0d->%0d: got %0d want %0d", old, val, ram[3], exp); end
  endtask

  task automatic test_append_tail();
    int lat;
    clear_ram();
    ram[0] = 16'd3;
    for (int i = 0; i < 3; i++) set_entry(i, 16'(i + 1), 16'd50);
    run_op(16'h44, 16'h55, 16'h99, 16'h66, lat);
    checks++; if (lat !== 14) begin errors++; $display("FAIL tail_lat: got %0d want 14", lat); end
    checks++; if ({ram[13], ram[14], ram[15], ram[16]} !== {16'h44, 16'h55, 16'h99, 16'h66}) begin errors++; $display("FAIL tail_entry: got %0h %0h %0h %0h", ram[13], ram[14], ram[15], ram[16]); end
    checks++; if (ram[0] !== 16'd4) begin errors++; $display("FAIL tail_cnt: got %0d want 4", ram[0]); end
    checks++; if ({matched, dropped, entry_index} !== {2'b00, 8'd3}) begin errors++; $display("FAIL tail_flags: got %b%b %0d want 00 3", matched, dropped, entry_index); end
  endtask

  task automatic test_drop(input logic [15:0] n);
    int lat;
    clear_ram();
    ram[0] = n;
    for (int i = 0; i < 8; i++) set_entry(i, 16'(16'h100 + i), 16'd5);
    run_op(16'h55, 16'h1, 16'h2, 16'h3, lat);
    checks++; if (lat !== 19) begin errors++; $display("FAIL drop%0d_lat: got %0d want 19", n, lat); end
    checks++; if (nw !== 0) begin errors++; $display("FAIL drop%0d_nw: got %0d want 0", n, nw); end
    checks++; if ({matched, dropped} !== 2'b01) begin errors++; $display("FAIL drop%0d_flags: got %b%b want 01", n, matched, dropped); end
  endtask

  task automatic test_reset_mid();
    int lat;
    clear_ram();
    @(negedge clock);
    fsourceID = 16'h5; fValue = 16'h64; start_learnCosts = 1'b1;
    @(posedge clock);
    #1 start_learnCosts = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    nreset = 1'b0;
    @(posedge clock);
    #1;
    checks++; if ({busy, done_learnCosts, mem_wr} !== 3'b000) begin errors++; $display("FAIL mid_ctl: got %b want 000", {busy, done_learnCosts, mem_wr}); end
    checks++; if (mem_addr !== 10'd0 || mem_wdata !== 16'd0) begin errors++; $display("FAIL mid_bus: got %0h %0h want 0 0", mem_addr, mem_wdata); end
    @(negedge clock);
    nreset = 1'b1;
    clear_ram();
    run_op(16'h5, 16'h50, 16'h64, 16'h2, lat);
    checks++; if (lat !== 8 || ram[0] !== 16'd1) begin errors++; $display("FAIL mid_rerun: got lat=%0d cnt=%0d want 8 1", lat, ram[0]); end
  endtask

  task automatic test_back_to_back();
    int dones;
    clear_ram();
    dones = 0;
    @(negedge clock);
    fsourceID = 16'h8; fValue = 16'h10; start_learnCosts = 1'b1;
    @(posedge clock);
    #1 start_learnCosts = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      start_learnCosts = 1'b0;
      if (c == 3) start_learnCosts = 1'b1;
      if (done_learnCosts) begin dones++; start_learnCosts = 1'b1; end
    end
    start_learnCosts = 1'b0;
    checks++; if (dones !== 1) begin errors++; $display("FAIL b2b_dones: got %0d want 1", dones); end
    checks++; if (ram[0] !== 16'd1) begin errors++; $display("FAIL b2b_cnt: got %0d want 1", ram[0]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", busy); end
  endtask

`ifdef LEARN_COSTS_BEST_EN
  task automatic test_best();
    int lat;
    clear_ram();
    run_op(16'h11, 16'h0, 16'd50, 16'h0, lat);
    run_op(16'h12, 16'h0, 16'd30, 16'h0, lat);
    checks++; if ({best_valid, best_id, best_cost} !== {1'b1, 16'h12, 16'd30}) begin errors++; $display("FAIL best_app: got %b %0h %0d want 1 12 30", best_valid, best_id, best_cost); end
    run_op(16'h12, 16'h0, 16'd70, 16'h0, lat);
    checks++; if (ram[7] !== 16'd40) begin errors++; $display("FAIL best_ram: got %0d want 40", ram[7]); end
    checks++; if ({best_id, best_cost} !== {16'h12, 16'd40}) begin errors++; $display("FAIL best_upd: got %0h %0d want 12 40", best_id, best_cost); end
  endtask
`endif

  initial begin
    test_reset();
    test_append_empty();
    test_hit(16'd100, 16'd200, 16'd125);
    test_hit(16'd200, 16'd100, 16'd175);
    test_rounding(16'd10, 16'd11, 16'd10);
    test_rounding(16'd11, 16'd10, 16'd10);
    test_append_tail();
    test_drop(16'd8);
    test_drop(16'd200);
    test_reset_mid();
    test_back_to_back();
`ifdef LEARN_COSTS_BEST_EN
    test_best();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
